bitty_mem_arbiter: RTL

//  Two-master arbiter sharing one synchronous single-port memory between the core's

---
 rtl/bitty_mem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bitty_mem_arbiter.sv
// bitty_mem_arbiter: shares one single-port RAM between the fetch port (M0) and the
// load/store port (M1). Define BITTY_ARB_RR_EN for round-robin instead of fixed M1 priority.
module bitty_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [DW-1:0]   if_rdata_o,
  input  logic            ls_req_i,
  input  logic            ls_we_i,
  input  logic [AW-1:0]   ls_addr_i,
  input  logic [DW-1:0]   ls_wdata_i,
  input  logic [DW/8-1:0] ls_wstrb_i,
  output logic            ls_gnt_o,
  output logic            ls_rvalid_o,
  output logic [DW-1:0]   ls_rdata_o,
  output logic            mem_ce_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_wstrb_o,
  input  logic [DW-1:0]   mem_rdata_i
);

  localparam int            CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_CNT = CW'(STARVE_MAX);
  localparam logic          OWN_IF     = 1'b0;
  localparam logic          OWN_LS     = 1'b1;

  typedef struct packed {
    logic vld;
    logic own;
  } tag_t;

  logic                  if_win, ls_win;
  logic [CW-1:0]         starve_q, starve_d;
  tag_t [MEM_LAT-1:0]    tag_pipe_q, tag_pipe_d;
  tag_t                  tag_new, tag_tail;

`ifdef BITTY_ARB_RR_EN
  logic last_q, last_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= OWN_LS;
    else      last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (ls_win)      last_d = OWN_LS;
    else if (if_win) last_d = OWN_IF;
  end
`endif

  // Grants are combinational and forced low while reset is held.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (rst) begin
      if (if_req_i && ls_req_i) begin
`ifdef BITTY_ARB_RR_EN
        if_win = (last_q == OWN_LS);
`else
        if_win = (starve_q == STARVE_CNT);
`endif
        ls_win = !if_win;
      end else begin
        if_win = if_req_i;
        ls_win = ls_req_i;
      end
    end
  end

  assign if_gnt_o = if_win;
  assign ls_gnt_o = ls_win;

  always_comb begin
    starve_d = '0;
`ifndef BITTY_ARB_RR_EN
    if (if_req_i && !if_win)
      starve_d = (starve_q == STARVE_CNT) ? starve_q : starve_q + CW'(1);
`endif
  end

  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    if (ls_win) begin
      mem_ce_o    = 1'b1;
      mem_we_o    = ls_we_i;
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_wdata_i;
      mem_wstrb_o = ls_wstrb_i;
    end else if (if_win) begin
      mem_ce_o    = 1'b1;
      mem_addr_o  = if_addr_i;
    end
  end

  // Writes occupy a pipe slot with vld=0 so later reads stay aligned to mem_rdata_i.
  always_comb begin
    tag_new.vld = ls_win ? !ls_we_i : if_win;
    tag_new.own = ls_win ? OWN_LS : OWN_IF;
    tag_pipe_d    = '0;
    tag_pipe_d[0] = tag_new;
    for (int i = 1; i < MEM_LAT; i++) tag_pipe_d[i] = tag_pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_pipe_q <= '0;
      starve_q   <= '0;
    end else begin
      tag_pipe_q <= tag_pipe_d;
      starve_q   <= starve_d;
    end
  end

  assign tag_tail    = tag_pipe_q[MEM_LAT-1];
  assign if_rvalid_o = tag_tail.vld && (tag_tail.own == OWN_IF);
  assign ls_rvalid_o = tag_tail.vld && (tag_tail.own == OWN_LS);
  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;

endmodule
